// File: rtl/alu_result_fifo.sv
// Decouples ALU result production from a slow writeback consumer: head visible 1 cycle after push, no bypass.
// Backpressure: in_ready = !full from registered pointers; refused pushes are dropped and the producer must hold.
module alu_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 16,
    parameter int CODE_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic                     in_overflow,
    input  logic [CODE_W-1:0]        in_code,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_overflow,
    output logic [CODE_W-1:0]        out_code,
    output logic                     out_is_cond,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     ovf_clear,
    output logic                     ovf_sticky,
    output logic [7:0]               ovf_count
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0]  result;
        logic              overflow;
        logic [CODE_W-1:0] code;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          ovf_event;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = wr_ptr - rd_ptr;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign ovf_event = push && in_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{result: in_result, overflow: in_overflow, code: in_code};
    end

    // A clear coinciding with an overflow push keeps the new event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= 8'd0;
        end else if (ovf_clear) begin
            ovf_sticky <= ovf_event;
            ovf_count  <= ovf_event ? 8'd1 : 8'd0;
        end else if (ovf_event) begin
            ovf_sticky <= 1'b1;
            if (ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
        end
    end

    always_comb begin
        head         = mem[rd_ptr[AW-1:0]];
        out_result   = '0;
        out_overflow = 1'b0;
        out_code     = '0;
        out_is_cond  = 1'b0;
        if (!empty) begin
            out_result   = head.result;
            out_overflow = head.overflow;
            out_code     = head.code;
            out_is_cond  = (head.code[CODE_W-1:CODE_W-2] == 2'b11);
        end
    end
endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: reset, fill/drain, streaming wrap, cond tag, overflow status, mid-run reset.
module tb_alu_result_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_result = '0;
    logic        in_overflow = 1'b0;
    logic [4:0]  in_code = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic        out_overflow;
    logic [4:0]  out_code;
    logic        out_is_cond;
    logic [2:0]  count;
    logic        ovf_clear = 1'b0;
    logic        ovf_sticky;
    logic [7:0]  ovf_count;

    int tests_run = 0;
    int fails = 0;

    alu_result_fifo #(.DEPTH(4), .WIDTH(16), .CODE_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_overflow(in_overflow), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_overflow(out_overflow), .out_code(out_code), .out_is_cond(out_is_cond),
        .count(count), .ovf_clear(ovf_clear), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_async_valid: got %b want 0", out_valid); end
        tick(); tick();
        rst_n = 1'b1;
        tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests_run++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        tests_run++; if ({out_result, out_overflow, out_code, out_is_cond} !== 23'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", {out_result, out_overflow, out_code, out_is_cond}); end
        tests_run++; if ({ovf_sticky, ovf_count} !== 9'd0) begin fails++; $display("FAIL reset_ovf: got %h want 0", {ovf_sticky, ovf_count}); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_result = 16'h1234; in_overflow = 1'b0; in_code = 5'b00000;
        tick();
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", out_valid); end
        tests_run++; if (out_result !== 16'h1234) begin fails++; $display("FAIL single_result: got %h want 1234", out_result); end
        tests_run++; if (count !== 3'd1) begin fails++; $display("FAIL single_count: got %0d want 1", count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_pop_valid: got %b want 0", out_valid); end
        tests_run++; if (out_result !== 16'h0000) begin fails++; $display("FAIL single_pop_result: got %h want 0000", out_result); end
    endtask

    task automatic test_fill_drain();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_result = 16'(i);
            tick();
        end
        in_result = 16'h0005;
        tests_run++; if (count !== 3'd4) begin fails++; $display("FAIL fill_count: got %0d want 4", count); end
        tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        tick();
        in_valid = 1'b0;
        tests_run++; if (count !== 3'd4) begin fails++; $display("FAIL fill_5th_ignored: got %0d want 4", count); end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tests_run++; if (out_result !== 16'(i) || out_valid !== 1'b1) begin fails++; $display("FAIL drain_order: got %h/%b want %h/1", out_result, out_valid, 16'(i)); end
            tick();
        end
        out_ready = 1'b0;
        tests_run++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: got count %0d valid %b want 0/0", count, out_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_result = 16'(100 + i);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_result = 16'(102 + k);
            tests_run++; if (out_result !== 16'(100 + k)) begin fails++; $display("FAIL stream_order: got %0d want %0d", out_result, 100 + k); end
            tick();
            tests_run++; if (count !== 3'd2) begin fails++; $display("FAIL stream_count: got %0d want 2", count); end
        end
        in_valid = 1'b0;
        for (int k = 20; k < 22; k++) begin
            tests_run++; if (out_result !== 16'(100 + k)) begin fails++; $display("FAIL stream_tail: got %0d want %0d", out_result, 100 + k); end
            tick();
        end
        out_ready = 1'b0;
        tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_cond();
        in_valid = 1'b1; in_result = 16'h0001; in_code = 5'b11001;
        tick();
        tests_run++; if (out_is_cond !== 1'b1 || out_result !== 16'h0001 || out_code !== 5'b11001) begin fails++; $display("FAIL cond_set: got %b/%h/%b want 1/0001/11001", out_is_cond, out_result, out_code); end
        out_ready = 1'b1; in_result = 16'h0055; in_code = 5'b01000;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        tests_run++; if (out_is_cond !== 1'b0 || out_code !== 5'b01000) begin fails++; $display("FAIL cond_clear: got %b/%b want 0/01000", out_is_cond, out_code); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_code = 5'b00000;
    endtask

    task automatic test_overflow();
        in_valid = 1'b1; in_overflow = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            in_result = 16'(i);
            tick();
            if (i == 10) begin
                tests_run++; if (ovf_count !== 8'd10) begin fails++; $display("FAIL ovf_count_mid: got %0d want 10", ovf_count); end
            end
        end
        in_valid = 1'b0;
        tests_run++; if (ovf_count !== 8'd255 || ovf_sticky !== 1'b1) begin fails++; $display("FAIL ovf_saturate: got %0d/%b want 255/1", ovf_count, ovf_sticky); end
        tests_run++; if (out_overflow !== 1'b1) begin fails++; $display("FAIL ovf_entry_bit: got %b want 1", out_overflow); end
        tick();
        out_ready = 1'b0;
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        tests_run++; if (ovf_count !== 8'd0 || ovf_sticky !== 1'b0) begin fails++; $display("FAIL ovf_clear_alone: got %0d/%b want 0/0", ovf_count, ovf_sticky); end
        in_valid = 1'b1;
        tick(); tick();
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        tests_run++; if (ovf_count !== 8'd1 || ovf_sticky !== 1'b1) begin fails++; $display("FAIL ovf_clear_with_push: got %0d/%b want 1/1", ovf_count, ovf_sticky); end
        in_overflow = 1'b0;
        tick();
        in_overflow = 1'b1; out_ready = 1'b1;
        tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_no_passthrough: got in_ready %b want 0", in_ready); end
        tick();
        in_valid = 1'b0; in_overflow = 1'b0;
        tests_run++; if (ovf_count !== 8'd1 || count !== 3'd3) begin fails++; $display("FAIL ovf_refused: got %0d/count %0d want 1/3", ovf_count, count); end
        tick(); tick(); tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_result = 16'(16'hA0 + i);
            tick();
        end
        in_result = 16'h00A3;
        tests_run++; if (count !== 3'd3) begin fails++; $display("FAIL mid_pre_count: got %0d want 3", count); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_now: got valid %b count %0d ready %b want 0/0/1", out_valid, count, in_ready); end
        tests_run++; if (ovf_sticky !== 1'b0 || ovf_count !== 8'd0) begin fails++; $display("FAIL mid_reset_ovf: got %b/%0d want 0/0", ovf_sticky, ovf_count); end
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1; in_result = 16'hBEEF;
        tick();
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1 || out_result !== 16'hBEEF || count !== 3'd1) begin fails++; $display("FAIL mid_first_push: got %b/%h/%0d want 1/beef/1", out_valid, out_result, count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++; if (out_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL mid_only_entry: got %b/%0d want 0/0", out_valid, count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_cond();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Buffers results leaving the 16-bit ALU so a slow consumer (writeback or result bus) cannot stall result production. Each accepted entry holds the result word, its overflow bit and the 5-bit ALU operation code that produced it. The block also keeps a sticky overflow flag and a saturating overflow counter for status readout. It sits directly downstream of the ALU: the ALU's C, overflow and alu_code feed the write side.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- WIDTH, 16, result width (matches ALU C)
- CODE_W, 5, ALU operation code width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ALU result present this cycle
- in_ready  out  1  FIFO can accept; = !full
- in_result  in  WIDTH  ALU result C
- in_overflow  in  1  ALU overflow
- in_code  in  CODE_W  alu_code of the operation
- out_valid  out  1  head entry present; = !empty
- out_ready  in  1  consumer takes head this cycle
- out_result  out  WIDTH  head result; 0 when out_valid=0
- out_overflow  out  1  head overflow; 0 when out_valid=0
- out_code  out  CODE_W  head code; 0 when out_valid=0
- out_is_cond  out  1  head is a set-condition op (out_code[4:3]==2'b11); 0 when empty
- count  out  clog2(DEPTH)+1  entries held, 0..DEPTH
- ovf_clear  in  1  synchronous clear of overflow status
- ovf_sticky  out  1  set by any accepted entry with overflow
- ovf_count  out  8  accepted entries with overflow, saturating at 255

## Operation
- Push: in_valid && in_ready at rising edge writes {in_result, in_overflow, in_code} at the write pointer; the write pointer advances.
- Pop: out_valid && out_ready at rising edge advances the read pointer; the head entry is discarded.
- Pointers are clog2(DEPTH)+1 bits wide. Index = low bits; wrap-around is natural modulo 2*DEPTH. Empty when the pointers are equal. Full when the indices are equal and the MSBs differ.
- count = wr_ptr - rd_ptr (modulo); it is registered or derived, but always consistent with the pointers in the same cycle.
- Push and pop in the same cycle are allowed whenever both handshakes fire. count is unchanged.
- When full, in_ready=0 even if out_ready=1. There is no pass-through on a full FIFO.
- When empty, a push is not visible on out_* until the next cycle. There is no combinational bypass.
- in_valid while in_ready=0: the data is dropped, not stalled. The producer must hold it. No status update occurs.
- Overflow status updates only on an accepted push with in_overflow=1:
  - ovf_sticky <= 1
  - ovf_count <= min(ovf_count+1, 255)
- ovf_clear=1 with no overflow push: ovf_sticky <= 0, ovf_count <= 0.
- ovf_clear=1 with an overflow push in the same cycle: ovf_sticky <= 1, ovf_count <= 1 (the new event survives the clear).
- Output fields are the head entry gated by out_valid, forced to 0 when empty.

## Timing
- Reset (rst_n low, asynchronous, any time including mid-transfer) sets:
  - both pointers to 0
  - count = 0, out_valid = 0, in_ready = 1
  - out_result = 0, out_overflow = 0, out_code = 0, out_is_cond = 0
  - ovf_sticky = 0, ovf_count = 0
- All held entries are lost on reset. Storage array contents need no reset.
- Deassertion of rst_n takes effect at the next rising edge. A push on the first edge after deassertion is accepted.
- Latency from push to out_valid on an empty FIFO: 1 cycle.
- Throughput: 1 push and 1 pop per cycle sustained when 0 < count < DEPTH.
- in_ready and out_valid depend only on registered state, never combinationally on in_valid or out_ready.
- ovf_sticky and ovf_count update at the same edge as the accepting push.

## Test plan
- Reset and single transfer:
  - after reset: in_ready=1, out_valid=0, count=0, all outputs 0
  - push C=16'h1234, ovf=0, code=5'b00000; next cycle: out_valid=1, out_result=16'h1234, count=1
  - pop: out_valid=0, out_result=0
- Fill and drain:
  - with out_ready=0, push 0x0001..0x0004; then count=4, in_ready=0
  - a 5th push of 0x0005 is ignored
  - drain with out_ready=1: outputs 0x0001..0x0004 in order, then count=0
- Simultaneous push/pop with wrap-around:
  - hold count=2 and stream 20 pushes/pops back-to-back
  - every result emerges in order, count stays 2, pointers wrap without loss
- Set-condition tag:
  - push code=5'b11001 (A<B) with result 1 -> out_is_cond=1, out_result=16'h0001
  - push code=5'b01000 -> out_is_cond=0
- Overflow status:
  - 300 accepted overflow pushes (draining concurrently) -> ovf_count=255, ovf_sticky=1
  - ovf_clear alone -> both 0
  - ovf_clear in the same cycle as an overflow push -> ovf_sticky=1, ovf_count=1
  - an overflow push refused while full -> no change
- Reset mid-operation:
  - with count=3 and a push in flight, pull rst_n low between edges
  - out_valid=0 and count=0 immediately
  - after release, the first push is the only entry output
